// File: rtl/sn74hc595_rx_if.sv
// Serial-side and parallel-side signals of the 74HC595-style receiver.
// The slave modport is the receiver; the master modport drives the serial lines.
interface sn74hc595_rx_if #(
   parameter int W = 8
);
   logic         SN74HC595_data;
   logic         SN74HC595_data_clk;
   logic         SN74HC595_refresh_clk;
   logic [W-1:0] o_buf;
   logic         o_valid;
   logic         o_qh_serial;
   logic         o_frame_err;

   modport master (
      output SN74HC595_data,
      output SN74HC595_data_clk,
      output SN74HC595_refresh_clk,
      input  o_buf,
      input  o_valid,
      input  o_qh_serial,
      input  o_frame_err
   );

   modport slave (
      input  SN74HC595_data,
      input  SN74HC595_data_clk,
      input  SN74HC595_refresh_clk,
      output o_buf,
      output o_valid,
      output o_qh_serial,
      output o_frame_err
   );
endinterface

// File: rtl/sn74hc595_rx.sv
// Oversampled receiver emulating a 74HC595 shift/storage register pair.
// Optional bit-count frame check enabled by macro SN74HC595_RX_FRAME_CHECK_EN.
module sn74hc595_rx #(
   parameter int W           = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   sn74hc595_rx_if.slave bus
);
   // bit 0 = data, bit 1 = data_clk, bit 2 = refresh_clk
   logic [2:0]   sync_r [SYNC_STAGES];
   logic [1:0]   hist_r;
   logic [2:0]   sync_out_s;
   logic         data_s;
   logic         shift_s;
   logic         latch_s;
   logic [W-1:0] shift_r;
   logic [W-1:0] shift_nxt_s;
   logic [W-1:0] buf_r;
   logic [W-1:0] buf_nxt_s;
   logic         valid_r;
   logic         err_r;
   logic         err_nxt_s;

   // Synchronizer chains for the three asynchronous serial inputs plus clock-line history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= 3'b000;
         end
         hist_r <= 2'b00;
      end else begin
         sync_r[0] <= {bus.SN74HC595_refresh_clk, bus.SN74HC595_data_clk, bus.SN74HC595_data};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
         hist_r <= sync_r[SYNC_STAGES-1][2:1];
      end
   end

   assign sync_out_s = sync_r[SYNC_STAGES-1];
   assign data_s     = sync_out_s[0];
   assign shift_s    = sync_out_s[1] & ~hist_r[0];
   assign latch_s    = sync_out_s[2] & ~hist_r[1];

   // Next shift/storage values; a coincident latch captures the pre-shift word.
   always_comb begin
      shift_nxt_s = shift_r;
      buf_nxt_s   = buf_r;
      if (shift_s) begin
         shift_nxt_s = {shift_r[W-2:0], data_s};
      end else begin
         shift_nxt_s = shift_r;
      end
      if (latch_s) begin
         buf_nxt_s = shift_r;
      end else begin
         buf_nxt_s = buf_r;
      end
   end

`ifdef SN74HC595_RX_FRAME_CHECK_EN
   logic [7:0] cnt_r;
   logic [7:0] cnt_nxt_s;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) begin
         return 8'hFF;
      end else begin
         return v + 8'd1;
      end
   endfunction

   // Bit counter clears on latch; a shift landing in the same cycle counts as the first bit.
   always_comb begin
      cnt_nxt_s = cnt_r;
      err_nxt_s = err_r;
      if (latch_s) begin
         err_nxt_s = ({24'd0, cnt_r} != 32'(W));
         cnt_nxt_s = shift_s ? 8'd1 : 8'd0;
      end else if (shift_s) begin
         err_nxt_s = err_r;
         cnt_nxt_s = sat_inc8(cnt_r);
      end else begin
         err_nxt_s = err_r;
         cnt_nxt_s = cnt_r;
      end
   end

   // Bit counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= 8'd0;
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end
`else
   // Frame checking not built: error flag is held low.
   always_comb begin
      err_nxt_s = 1'b0;
   end
`endif

   // Shift register, storage register and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_r <= {W{1'b0}};
         buf_r   <= {W{1'b0}};
         valid_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         shift_r <= shift_nxt_s;
         buf_r   <= buf_nxt_s;
         valid_r <= latch_s;
         err_r   <= err_nxt_s;
      end
   end

   assign bus.o_buf       = buf_r;
   assign bus.o_valid     = valid_r;
   assign bus.o_qh_serial = shift_r[W-1];
   assign bus.o_frame_err = err_r;
endmodule

// File: tb/tb_sn74hc595_rx.sv
// Randomized self-checking bench for sn74hc595_rx against a word-level model.
module tb_sn74hc595_rx;
   localparam int W   = 8;
   localparam int S   = 2;
   localparam int GAP = S + 3;
`ifdef SN74HC595_RX_FRAME_CHECK_EN
   localparam bit FC = 1'b1;
`else
   localparam bit FC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   // Model: value of the register as an integer, bits since last latch, stored word.
   int unsigned m_sr  = 0;
   int unsigned m_cnt = 0;
   int unsigned m_buf = 0;
   bit          m_err = 1'b0;

   sn74hc595_rx_if #(.W(W)) bus ();
   sn74hc595_rx #(.W(W), .SYNC_STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic int unsigned mask_w();
      return (32'd1 << W) - 32'd1;
   endfunction

   task automatic m_shift(input bit b);
      m_sr  = ((m_sr * 2) + b) & mask_w();
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
   endtask

   task automatic m_latch();
      m_buf = m_sr;
      m_err = FC && (m_cnt != W);
      m_cnt = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic shift_bit(input bit b);
      bus.SN74HC595_data = b;
      idle(GAP);
      bus.SN74HC595_data_clk = 1'b1;
      m_shift(b);
      idle(GAP);
      checks++;
      if (bus.o_qh_serial !== m_sr[W-1]) begin
         failures++;
         $display("FAIL qh_serial: got %0b expected %0b", bus.o_qh_serial, m_sr[W-1]);
      end
      checks++;
      if (bus.o_buf !== m_buf[W-1:0]) begin
         failures++;
         $display("FAIL buf_hold: got %0h expected %0h", bus.o_buf, m_buf[W-1:0]);
      end
      bus.SN74HC595_data_clk = 1'b0;
      idle(GAP);
   endtask

   task automatic shift_word(input int unsigned val, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         shift_bit(bit'((val >> i) & 1));
      end
   endtask

   // Raise refresh (optionally together with a shift of bit b) and check the latch timing.
   task automatic do_refresh(input bit with_shift, input bit b);
      int unsigned old_buf;
      int pulses;
      old_buf = m_buf;
      pulses  = 0;
      if (with_shift) begin
         bus.SN74HC595_data = b;
         idle(GAP);
      end
      bus.SN74HC595_refresh_clk = 1'b1;
      if (with_shift) bus.SN74HC595_data_clk = 1'b1;
      m_latch();
      if (with_shift) m_shift(b);
      for (int k = 1; k <= S + 3; k++) begin
         @(negedge clk);
         if (bus.o_valid === 1'b1) pulses++;
         if (k == S) begin
            checks++;
            if (bus.o_buf !== old_buf[W-1:0]) begin
               failures++;
               $display("FAIL buf_early: got %0h expected %0h", bus.o_buf, old_buf[W-1:0]);
            end
         end
         if (k == S + 1) begin
            checks++;
            if (bus.o_valid !== 1'b1) begin
               failures++;
               $display("FAIL valid_latency: got %0b expected 1", bus.o_valid);
            end
            checks++;
            if (bus.o_buf !== m_buf[W-1:0]) begin
               failures++;
               $display("FAIL buf_latched: got %0h expected %0h", bus.o_buf, m_buf[W-1:0]);
            end
            checks++;
            if (bus.o_frame_err !== m_err) begin
               failures++;
               $display("FAIL frame_err: got %0b expected %0b", bus.o_frame_err, m_err);
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL valid_pulses: got %0d expected 1", pulses);
      end
      if (with_shift) begin
         checks++;
         if (bus.o_qh_serial !== m_sr[W-1]) begin
            failures++;
            $display("FAIL qh_after_simul: got %0b expected %0b", bus.o_qh_serial, m_sr[W-1]);
         end
      end
      bus.SN74HC595_refresh_clk = 1'b0;
      bus.SN74HC595_data_clk    = 1'b0;
      idle(GAP);
   endtask

   // Asynchronous reset pulse away from the clock edge; outputs must clear at once.
   task automatic apply_reset();
      bus.SN74HC595_data_clk    = 1'b0;
      bus.SN74HC595_refresh_clk = 1'b0;
      bus.SN74HC595_data        = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.o_buf, bus.o_valid, bus.o_frame_err, bus.o_qh_serial} !== {W+3{1'b0}}) begin
         failures++;
         $display("FAIL reset_outputs: got buf=%0h v=%0b e=%0b q=%0b expected all 0",
                  bus.o_buf, bus.o_valid, bus.o_frame_err, bus.o_qh_serial);
      end
      m_sr = 0; m_cnt = 0; m_buf = 0; m_err = 1'b0;
      idle(2);
      rst = 1'b0;
      idle(GAP);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_buf !== {W{1'b0}}) begin
         failures++;
         $display("FAIL reset_release: got v=%0b buf=%0h expected 0", bus.o_valid, bus.o_buf);
      end
   endtask

   task automatic test_basic_frame();
      shift_word(32'hA5, 8);
      do_refresh(1'b0, 1'b0);
   endtask

   task automatic test_short_frame();
      apply_reset();
      shift_word(32'h16, 5);
      do_refresh(1'b0, 1'b0);
      shift_word(32'h5A, 8);
      do_refresh(1'b0, 1'b0);
   endtask

   task automatic test_simultaneous();
      shift_word(32'h3C, 8);
      do_refresh(1'b1, 1'b1);
      do_refresh(1'b0, 1'b0);
   endtask

   task automatic test_reset_midframe();
      shift_word(32'hFF, 8);
      shift_word(32'h00, 4);
      apply_reset();
      shift_word(32'h81, 8);
      do_refresh(1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      shift_word(32'hC3, 8);
      do_refresh(1'b0, 1'b0);
      do_refresh(1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int f = 0; f < 8; f++) begin
         int n;
         n = int'($urandom_range(1, 12));
         shift_word($urandom, n);
         do_refresh(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      bus.SN74HC595_data        = 1'b0;
      bus.SN74HC595_data_clk    = 1'b0;
      bus.SN74HC595_refresh_clk = 1'b0;
      test_reset();
      test_basic_frame();
      test_short_frame();
      test_simultaneous();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sn74hc595_rx.md
SN74HC595_RX -- requirements
Module: sn74hc595_rx

Interface
REQ-001 Parameter W, default 8, SHALL set the shift/storage register width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth per serial input (minimum 2).
REQ-003 Port clk, input, 1, SHALL be the single system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be an asynchronous, active-high reset.
REQ-005 Port SN74HC595_data, input, 1, SHALL carry serial data, asynchronous to clk.
REQ-006 Port SN74HC595_data_clk, input, 1, SHALL carry the shift clock; data is captured on its rising edge.
REQ-007 Port SN74HC595_refresh_clk, input, 1, SHALL carry the storage clock; latch occurs on its rising edge.
REQ-008 Port o_buf, output, W, SHALL present the storage register, the last latched word.
REQ-009 Port o_valid, output, 1, SHALL pulse high for one clk cycle per latch.
REQ-010 Port o_qh_serial, output, 1, SHALL present the shift register MSB, the cascade output.
REQ-011 Port o_frame_err, output, 1, SHALL flag a latch with a wrong bit count (REQ-020/021).

Function
REQ-012 Each of the three serial inputs SHALL pass through a SYNC_STAGES-deep flop chain, plus one history flop for edge detection.
REQ-013 A rising edge SHALL be detected as sync output 1 and history 0; each physical edge SHALL produce exactly one detect pulse.
REQ-014 On a data_clk edge, shift_reg SHALL take {shift_reg[W-2:0], synced data}, MSB-first, so the first bit shifted ends at bit W-1 after W shifts.
REQ-015 On a refresh_clk edge, o_buf SHALL take the pre-shift value of shift_reg, and o_valid SHALL be 1 in the following cycle.
REQ-016 When data_clk and refresh_clk edges are detected in the same cycle: latch old shift_reg, and perform the shift, both in that cycle.
REQ-017 Latency from an input edge to the o_buf/o_valid update SHALL be SYNC_STAGES+1 clk cycles.
REQ-018 Serial edges SHALL be separated by at least SYNC_STAGES+2 clk periods; faster toggling is unsupported and need not be detected.
REQ-019 o_buf SHALL hold between latches; shifting SHALL NOT disturb o_buf.

Reset
REQ-022 On rst high, immediately and asynchronously: shift_reg=0, o_buf=0, o_valid=0, o_frame_err=0, bit counter=0; sync and history flops=0.
REQ-023 Reset mid-frame SHALL discard partial bits; the first frame after release SHALL be counted from zero.
REQ-024 While rst is high and for SYNC_STAGES cycles after release, no edge SHALL be detected from inputs already high (history starts 0, so an input held high yields one edge after release; this is accepted behaviour).

Configuration
REQ-020 With macro SN74HC595_RX_FRAME_CHECK_EN defined: an 8-bit saturating bit counter SHALL increment per shift (saturates at 255) and clear on latch. With a simultaneous shift it SHALL become 1.
REQ-021 With SN74HC595_RX_FRAME_CHECK_EN defined: at each latch, o_frame_err SHALL become (counter != W) and hold until the next latch. Without the macro: no counter is built and o_frame_err SHALL be tied 0.

Verification
REQ-025 Scenario: shift 0xA5 MSB-first, 8 clocks, then refresh -> o_buf=0xA5 SYNC_STAGES+1 cycles after the refresh edge, o_valid high 1 cycle, o_frame_err=0.
REQ-026 Scenario: shift 5 bits (1,0,1,1,0) then refresh, macro on -> o_buf=0x16, o_frame_err=1; the next full 8-bit frame clears it to 0.
REQ-027 Scenario: shift 0x3C, then a further bit 1 with data_clk and refresh_clk rising together -> o_buf=0x3C, shift_reg=0x79, counter=1.
REQ-028 Scenario: shift 0xFF, assert rst mid-frame after 4 bits of 0x00, release, then shift 0x81 and refresh -> o_buf=0x81, o_frame_err=0.
REQ-029 Scenario: macro off, 3-bit frame then refresh -> o_frame_err stays 0, o_valid pulses once; o_qh_serial tracks shift_reg[W-1] after every shift.
